// File: rtl/itu656_pkg.sv
// Shared constants and helpers for the BT.656 525/60 encoder.
package itu656_pkg;

  localparam logic [7:0] SYNC_FF  = 8'hFF;
  localparam logic [7:0] SYNC_00  = 8'h00;
  localparam logic [7:0] BLANK_C  = 8'h80;
  localparam logic [7:0] BLANK_Y  = 8'h10;
  localparam logic [7:0] CLAMP_LO = 8'h01;
  localparam logic [7:0] CLAMP_HI = 8'hFE;

  localparam logic [9:0] F0_FIRST = 10'd3;
  localparam logic [9:0] F0_LAST  = 10'd264;
  localparam logic [9:0] V_END0   = 10'd18;
  localparam logic [9:0] V_START1 = 10'd263;
  localparam logic [9:0] V_END1   = 10'd281;

  // Region of the byte about to be driven.
  typedef enum logic [1:0] {RGN_ACT, RGN_EAV, RGN_BLANK, RGN_SAV} rgn_e;

  function automatic logic f_flag(input logic [9:0] line);
    return !(line >= F0_FIRST && line <= F0_LAST);
  endfunction

  function automatic logic v_flag(input logic [9:0] line);
    return (line <= V_END0) || (line >= V_START1 && line <= V_END1);
  endfunction

  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Byte idx (0..3) of a timing reference code FF 00 00 XY.
  function automatic logic [7:0] trs_byte(input logic [1:0] idx, input logic f,
                                          input logic v, input logic h);
    logic [7:0] b;
    b = SYNC_00;
    if (idx == 2'd0) b = SYNC_FF;
    else if (idx == 2'd3) b = xy_code(f, v, h);
    return b;
  endfunction

  // Keep active samples out of the reserved 00/FF sync values.
  function automatic logic [7:0] clamp_byte(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b == SYNC_00) r = CLAMP_LO;
    else if (b == SYNC_FF) r = CLAMP_HI;
    return r;
  endfunction

endpackage

// File: rtl/itu_656_encoder_if.sv
// Pixel fetch and BT.656 output bundle of the encoder.
interface itu_656_encoder_if;
  logic [15:0] iYCbCr;
  logic        oRequest;
  logic [7:0]  oTD_DATA;
  logic        oField;
  logic        oVBlank;
  logic [9:0]  oLine;

  modport master (input iYCbCr, output oRequest, oTD_DATA, oField, oVBlank, oLine);
  modport slave  (output iYCbCr, input oRequest, oTD_DATA, oField, oVBlank, oLine);
endinterface

// File: rtl/itu656_timing.sv
// h/v raster counters; decodes flags, region and fetch slot for the
// position that will be on the output after the next clock edge.
module itu656_timing
  import itu656_pkg::*;
#(
  parameter int H_ACTIVE = 1440,
  parameter int H_BLANK  = 268,
  parameter int V_TOTAL  = 525
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] line,
  output rgn_e       nxt_rgn,
  output logic [1:0] nxt_idx,
  output logic       nxt_odd,
  output logic       nxt_f,
  output logic       nxt_v,
  output logic       sav_f,
  output logic       sav_v,
  output logic       nxt_req
);

  localparam int         H_TOTAL  = H_ACTIVE + H_BLANK + 8;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] EAV_AT  = 11'(H_ACTIVE);
  localparam logic [10:0] SAV_AT  = 11'(H_TOTAL - 4);
  localparam logic [10:0] REQ_LST = 11'(H_ACTIVE - 5);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  logic [10:0] h, h_n;
  logic [9:0]  v, v_n, v_nn;

  // Next raster position, plus the line after it (SAV carries that line's flags).
  always_comb begin
    h_n = h + 11'd1;
    v_n = v;
    if (h == H_LAST) begin
      h_n = '0;
      v_n = (v == V_LAST) ? '0 : v + 10'd1;
    end
    v_nn = (v_n == V_LAST) ? '0 : v_n + 10'd1;
  end

  // Raster counters track the byte currently on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_n;
      v <= v_n;
    end
  end

  // Region decode; fetch slot sits 3 bytes ahead of each chroma byte, so
  // pixels 0 and 1 are fetched during the previous line's SAV.
  always_comb begin
    nxt_rgn = RGN_BLANK;
    nxt_idx = 2'(h_n - EAV_AT);
    if (h_n < EAV_AT) nxt_rgn = RGN_ACT;
    else if (h_n < EAV_AT + 11'd4) nxt_rgn = RGN_EAV;
    else if (h_n >= SAV_AT) begin
      nxt_rgn = RGN_SAV;
      nxt_idx = 2'(h_n - SAV_AT);
    end
    nxt_req = (!v_flag(v_n) && h_n[0] && h_n <= REQ_LST) ||
              (!v_flag(v_nn) && (h_n == SAV_AT + 11'd1 || h_n == H_LAST));
  end

  assign line    = v;
  assign nxt_odd = h_n[0];
  assign nxt_f   = f_flag(v_n);
  assign nxt_v   = v_flag(v_n);
  assign sav_f   = f_flag(v_nn);
  assign sav_v   = v_flag(v_nn);

endmodule

// File: rtl/itu_656_encoder.sv
// BT.656 525/60 byte-stream encoder: fetch pipeline, byte mux and clamp.
module itu_656_encoder
  import itu656_pkg::*;
#(
  parameter int H_ACTIVE = 1440,
  parameter int H_BLANK  = 268,
  parameter int V_TOTAL  = 525
) (
  input  logic                iCLK_27,
  input  logic                iRST_N,
  itu_656_encoder_if.master   bus
);

  localparam int STAGES = 1;

  logic [9:0]      line;
  rgn_e            nxt_rgn;
  logic [1:0]      nxt_idx;
  logic            nxt_odd, nxt_f, nxt_v, sav_f, sav_v, nxt_req;
  logic [STAGES:0] vld_pipe;   // [0]: request on the bus, [1]: pixel valid at input
  logic [15:0]     pix_q;
  logic [7:0]      td_q, byte_n;
  logic            field_q, vblank_q;

  itu656_timing #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_TOTAL(V_TOTAL)
  ) u_timing (
    .clk(iCLK_27), .rst_n(iRST_N), .line(line),
    .nxt_rgn(nxt_rgn), .nxt_idx(nxt_idx), .nxt_odd(nxt_odd),
    .nxt_f(nxt_f), .nxt_v(nxt_v), .sav_f(sav_f), .sav_v(sav_v),
    .nxt_req(nxt_req)
  );

  // Select the next stream byte: fill, EAV/SAV code or clamped pixel data.
  always_comb begin
    byte_n = nxt_odd ? BLANK_Y : BLANK_C;
    unique case (nxt_rgn)
      RGN_ACT: if (!nxt_v) byte_n = nxt_odd ? clamp_byte(pix_q[15:8]) : clamp_byte(pix_q[7:0]);
      RGN_EAV: byte_n = trs_byte(nxt_idx, nxt_f, nxt_v, 1'b1);
      RGN_SAV: byte_n = trs_byte(nxt_idx, sav_f, sav_v, 1'b0);
      default: ;
    endcase
  end

  // Output registers and fetch pipeline; pixel captured one cycle after its request.
  always_ff @(posedge iCLK_27 or negedge iRST_N) begin
    if (!iRST_N) begin
      td_q     <= BLANK_C;
      field_q  <= 1'b1;
      vblank_q <= 1'b1;
      vld_pipe <= '0;
      pix_q    <= '0;
    end else begin
      td_q     <= byte_n;
      field_q  <= nxt_f;
      vblank_q <= nxt_v;
      vld_pipe <= {vld_pipe[STAGES-1:0], nxt_req};
      if (vld_pipe[STAGES]) pix_q <= bus.iYCbCr;
    end
  end

  assign bus.oRequest = vld_pipe[0];
  assign bus.oTD_DATA = td_q;
  assign bus.oField   = field_q;
  assign bus.oVBlank  = vblank_q;
  assign bus.oLine    = line;

endmodule

// File: tb/tb_itu_656_encoder.sv
// Scoreboard bench for itu_656_encoder with a shortened line (16 active bytes).
module tb_itu_656_encoder;

  localparam int HA = 16, HB = 8, HT = HA + HB + 8, VT = 525, PIX = HA / 2;
  localparam int FRAME = HT * VT;
  localparam int REQS  = 487 * PIX;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  itu_656_encoder_if bus();

  itu_656_encoder #(.H_ACTIVE(HA), .H_BLANK(HB), .V_TOTAL(VT)) dut (
    .iCLK_27(clk), .iRST_N(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int th = 0, tv = 0, wraps = 0;
  logic [7:0] expq[$];
  // Standard XY values indexed by {F,V,H}.
  logic [7:0] xytab [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s line %0d h %0d: got %0h want %0h", name, tv, th, act, exp);
    end
  endtask

  function automatic bit lv(int l); return (l <= 18) || (l >= 263 && l <= 281); endfunction
  function automatic bit lf(int l); return !(l >= 3 && l <= 264); endfunction
  function automatic logic [7:0] fill(int h); return (h % 2 != 0) ? 8'h10 : 8'h80; endfunction
  function automatic logic [7:0] trs(int i, bit f, bit v, bit h);
    if (i == 0) return 8'hFF;
    if (i == 3) return xytab[{f, v, h}];
    return 8'h00;
  endfunction

  // Frame-buffer model: answers each request one cycle later, pushes expected bytes.
  initial begin : source
    bit rp;
    int n, idx, pat;
    logic [7:0] y, c, ec, ey;
    rp = 1'b0; n = 0;
    bus.iYCbCr = 16'hA5A5;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rp = 1'b0; n = 0; bus.iYCbCr = 16'hA5A5;
      end else begin
        if (rp) begin
          idx = n % PIX; pat = (n / PIX) % 3;
          case (pat)
            0:       begin y = 8'h55; c = 8'(idx); ey = 8'h55; ec = (idx == 0) ? 8'h01 : 8'(idx); end
            1:       begin y = 8'hFF; c = 8'h00; ec = 8'h01; ey = 8'hFE; end
            default: begin y = 8'h10; c = 8'h80; ec = 8'h80; ey = 8'h10; end
          endcase
          bus.iYCbCr = {y, c};
          expq.push_back(ec);
          expq.push_back(ey);
          n++;
        end else begin
          bus.iYCbCr = 16'hA5A5;
        end
        rp = bus.oRequest;
      end
    end
  end

  // Monitor: checks every output byte, flags and request against the raster model.
  initial begin : monitor
    int nl, ah, al, cyc, reqs, pline;
    bit rq, pv, have;
    logic pfield;
    logic [7:0] eb;
    cyc = 0; reqs = 0; pline = 0; pv = 1'b0; pfield = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_td_data", bus.oTD_DATA, 8'h80);
        chk("rst_request", bus.oRequest, 0);
        chk("rst_field",   bus.oField, 1);
        chk("rst_vblank",  bus.oVBlank, 1);
        chk("rst_line",    bus.oLine, 0);
        th = 0; tv = 0; wraps = 0; cyc = 0; reqs = 0; pv = 1'b0;
        expq.delete();
      end else begin
        nl = (tv == VT - 1) ? 0 : tv + 1;
        have = 1'b1;
        eb = 8'h00;
        if (th < HA) begin
          if (lv(tv)) eb = fill(th);
          else if (expq.size() == 0) begin
            have = 1'b0; tests++; fails++;
            $display("FAIL scoreboard line %0d h %0d: got %0h want a queued pixel byte", tv, th, bus.oTD_DATA);
          end else eb = expq.pop_front();
        end else if (th < HA + 4) eb = trs(th - HA, lf(tv), lv(tv), 1'b1);
        else if (th < HT - 4)     eb = fill(th);
        else                      eb = trs(th - (HT - 4), lf(nl), lv(nl), 1'b0);
        if (have) chk("td_data", bus.oTD_DATA, eb);
        ah = th + 3; al = tv;
        if (ah >= HT) begin ah -= HT; al = nl; end
        rq = !lv(al) && ah < HA && (ah % 2 == 0);
        chk("request", bus.oRequest, rq);
        chk("line",    bus.oLine, tv);
        chk("field",   bus.oField, lf(tv));
        chk("vblank",  bus.oVBlank, lv(tv));
        cyc++;
        if (bus.oRequest) reqs++;
        if (pv && pline == VT - 1 && bus.oLine == 0) begin
          if (wraps > 0) begin
            chk("frame_cycles",   cyc, FRAME);
            chk("frame_requests", reqs, REQS);
          end
          wraps++; cyc = 0; reqs = 0;
        end
        if (pv && pfield !== bus.oField) chk("field_toggle_line", bus.oLine, pfield ? 3 : 265);
        pline = bus.oLine; pfield = bus.oField; pv = 1'b1;
        th++;
        if (th == HT) begin th = 0; tv = nl; end
      end
    end
  end

  // Reset sequencing: power-on reset, two full frames, mid-line reset, restart.
  initial begin : stim
    bit hit;
    hit = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 60000 && !hit; i++) begin
      @(posedge clk);
      if (wraps >= 2 && tv == 150 && th == 7) hit = 1'b1;
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL mid_reset_reach: got line %0d h %0d want line 150 h 7", tv, th);
    end else begin
      #2 rst_n = 1'b0;
      #1;
      chk("async_td_data", bus.oTD_DATA, 8'h80);
      chk("async_request", bus.oRequest, 0);
      chk("async_field",   bus.oField, 1);
      chk("async_vblank",  bus.oVBlank, 1);
      chk("async_line",    bus.oLine, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (25 * HT) @(posedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
